tc_pl_cap_data_mc: RTL and testbench

Multi-phase capture-to-memory engine, the parametrised successor to the single-pass capture/ACP data path. On `data_en` it captures 1..2^PHASE_W phases in sequence: it triggers the merge front end per phase and buffers samples in an internal FIFO. It then writes the samples to system memory as fixed-length ACP bursts at a per-phase strided address, and reports one CRC32 over all real beats. It sits between the capture merge logic (`Gc_*`) and the ACP0 write master (`acp0_tx_*`).

---
 rtl/tc_pl_cap_data_mc.sv | 204 ++++++++++++++++++++
 tb/tb_tc_pl_cap_data_mc.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_pl_cap_data_mc.sv
// Multi-phase capture engine: triggers the merge front end once per phase, buffers samples
// in a FIFO, drains them as fixed-length ACP bursts and reports one CRC32 over real beats.
module tc_pl_cap_data_mc #(
    parameter int PHASE_W   = 2,
    parameter int POINT_W   = 14,
    parameter int ADDR_W    = 32,
    parameter int DIN_W     = 56,
    parameter int BEAT_W    = 64,
    parameter int FIFO_AW   = 6,
    parameter int BURST_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_en,
    output logic               data_cmpt,
    output logic               busy,
    input  logic [PHASE_W-1:0] cap_phase_number,
    input  logic [POINT_W-1:0] cap_points,
    input  logic [ADDR_W-1:0]  cap_addr,
    input  logic [ADDR_W-1:0]  cap_stride,
    output logic [31:0]        cap_crc32,
    output logic               Gc_cap_trig,
    input  logic               Gc_capr_rdy,
    output logic               Gc_cap_cmpt,
    output logic [PHASE_W-1:0] Gc_cap_phase,
    input  logic [DIN_W-1:0]   Gc_merge_data,
    input  logic               Gc_mereg_datv,
    output logic               Gc_mereg_datr,
    output logic               acp0_tx_en,
    input  logic               acp0_tx_rdy,
    output logic [31:0]        acp0_tx_awaddr,
    output logic [2:0]         acp0_tx_awid,
    output logic [BEAT_W-1:0]  acp0_tx_wdata,
    input  logic               acp0_tx_wdreq,
    output logic [2:0]         cap_state_dbg,
    output logic [1:0]         burst_state_dbg
);
    localparam int LVL_W = FIFO_AW + 1;
    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [LVL_W-1:0]  FIFO_DEPTH  = LVL_W'(1 << FIFO_AW);
    localparam logic [LVL_W-1:0]  BURST_LVL   = LVL_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  BURST_CNT   = CNT_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * BEAT_W / 8);
    localparam logic [31:0]       CRC_POLY    = 32'h04C1_1DB7;

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_ARM, S_CAP, S_FLUSH, S_DONE} cap_state_t;
    typedef enum logic [1:0] {B_IDLE, B_REQ, B_DATA} burst_state_t;

    cap_state_t   cap_state, cap_next;
    burst_state_t b_state, b_next;

    logic [PHASE_W-1:0] phase, phase_last;
    logic [POINT_W-1:0] points, remaining;
    logic [ADDR_W-1:0]  stride, phase_base, burst_addr, awaddr_q;
    logic [31:0]        crc;
    logic [BEAT_W-1:0]  fifo_mem [0:(1<<FIFO_AW)-1];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [CNT_W-1:0]   beat_cnt, real_cnt;
    logic push, pop, wdreq_beat, last_sample, burst_start, burst_accept, burst_last;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [BEAT_W-1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = BEAT_W - 1; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    // Handshakes: a sample moves on a rising edge with Gc_mereg_datv & Gc_mereg_datr high; a burst
    // is granted on an edge with acp0_tx_en & acp0_tx_rdy high, then each sampled acp0_tx_wdreq
    // consumes one beat whose data appears on acp0_tx_wdata in the following cycle.
    assign Gc_mereg_datr = (cap_state == S_CAP) && (level != FIFO_DEPTH) && (remaining != '0);
    assign push          = Gc_mereg_datv && Gc_mereg_datr;
    assign last_sample   = push && (remaining == POINT_W'(1));
    assign wdreq_beat    = (b_state == B_DATA) && acp0_tx_wdreq;
    assign pop           = wdreq_beat && (beat_cnt < real_cnt);
    assign burst_last    = wdreq_beat && (beat_cnt == BURST_CNT - CNT_W'(1));
    assign burst_accept  = (b_state == B_REQ) && acp0_tx_rdy;
    assign burst_start   = (b_state == B_IDLE) &&
                           ((level >= BURST_LVL) || ((cap_state == S_FLUSH) && (level != '0)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_state <= S_IDLE;
            b_state   <= B_IDLE;
        end else begin
            cap_state <= cap_next;
            b_state   <= b_next;
        end
    end

    always_comb begin
        cap_next = cap_state;
        case (cap_state)
            S_IDLE:  if (data_en) cap_next = S_TRIG;
            S_TRIG:  cap_next = S_ARM;
            S_ARM:   if (Gc_capr_rdy) cap_next = (points == '0) ? S_FLUSH : S_CAP;
            S_CAP:   if (last_sample) cap_next = S_FLUSH;
            S_FLUSH: if ((level == '0) && (b_state == B_IDLE))
                         cap_next = (phase == phase_last) ? S_DONE : S_TRIG;
            S_DONE:  cap_next = S_IDLE;
            default: cap_next = S_IDLE;
        endcase
    end

    always_comb begin
        b_next = b_state;
        case (b_state)
            B_IDLE:  if (burst_start) b_next = B_REQ;
            B_REQ:   if (acp0_tx_rdy) b_next = B_DATA;
            B_DATA:  if (burst_last) b_next = B_IDLE;
            default: b_next = B_IDLE;
        endcase
    end

    always_comb begin
        busy            = (cap_state != S_IDLE);
        data_cmpt       = (cap_state == S_DONE);
        Gc_cap_trig     = (cap_state == S_TRIG);
        Gc_cap_cmpt     = ((cap_state == S_ARM) && Gc_capr_rdy && (points == '0)) ||
                          ((cap_state == S_CAP) && last_sample);
        Gc_cap_phase    = phase;
        acp0_tx_awid    = 3'(phase);
        acp0_tx_en      = (b_state == B_REQ);
        acp0_tx_awaddr  = 32'(awaddr_q);
        cap_state_dbg   = cap_state;
        burst_state_dbg = b_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase         <= '0;
            phase_last    <= '0;
            points        <= '0;
            remaining     <= '0;
            stride        <= '0;
            phase_base    <= '0;
            burst_addr    <= '0;
            awaddr_q      <= '0;
            crc           <= '0;
            cap_crc32     <= '0;
            beat_cnt      <= '0;
            real_cnt      <= '0;
            acp0_tx_wdata <= '0;
        end else begin
            if ((cap_state == S_IDLE) && data_en) begin
                phase      <= '0;
                phase_last <= cap_phase_number;
                points     <= cap_points;
                stride     <= cap_stride;
                phase_base <= cap_addr;
                burst_addr <= cap_addr;
                crc        <= 32'hFFFF_FFFF;
            end
            if ((cap_state == S_ARM) && Gc_capr_rdy) remaining <= points;
            if (push) begin
                remaining <= remaining - POINT_W'(1);
                crc       <= crc_step(crc, BEAT_W'(Gc_merge_data));
            end
            // The burst address restarts at the next phase's region base.
            if ((cap_state == S_FLUSH) && (cap_next == S_TRIG)) begin
                phase      <= phase + PHASE_W'(1);
                phase_base <= phase_base + stride;
                burst_addr <= phase_base + stride;
            end
            if ((cap_state == S_FLUSH) && (cap_next == S_DONE)) cap_crc32 <= ~crc;
            if (burst_start) begin
                awaddr_q <= burst_addr;
                real_cnt <= (level >= BURST_LVL) ? BURST_CNT : CNT_W'(level);
            end
            if (burst_accept) begin
                burst_addr <= burst_addr + BURST_BYTES;
                beat_cnt   <= '0;
            end
            if (wdreq_beat) begin
                beat_cnt      <= beat_cnt + CNT_W'(1);
                acp0_tx_wdata <= pop ? fifo_mem[rd_ptr] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= BEAT_W'(Gc_merge_data);
    end
endmodule

// File: tb/tb_tc_pl_cap_data_mc.sv
// Bench for tc_pl_cap_data_mc: directed capture jobs, an ACP responder, and a monitor that
// checks bursts, beats and CRCs against expectations queued when each job is issued.
module tb_tc_pl_cap_data_mc;
    localparam int PHASE_W = 2, POINT_W = 14, ADDR_W = 32, DIN_W = 56, BEAT_W = 64;
    localparam int FIFO_AW = 6, BURST_LEN = 16, BURST_BYTES = 128, BOUND = 2000;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               data_en = 1'b0;
    logic               data_cmpt, busy;
    logic [PHASE_W-1:0] cap_phase_number = '0;
    logic [POINT_W-1:0] cap_points = '0;
    logic [ADDR_W-1:0]  cap_addr = '0;
    logic [ADDR_W-1:0]  cap_stride = '0;
    logic [31:0]        cap_crc32;
    logic               Gc_cap_trig, Gc_cap_cmpt, Gc_mereg_datr;
    logic               Gc_capr_rdy = 1'b1;
    logic [PHASE_W-1:0] Gc_cap_phase;
    logic [DIN_W-1:0]   Gc_merge_data = '0;
    logic               Gc_mereg_datv = 1'b0;
    logic               acp0_tx_en;
    logic               acp0_tx_rdy = 1'b0;
    logic [31:0]        acp0_tx_awaddr;
    logic [2:0]         acp0_tx_awid;
    logic [BEAT_W-1:0]  acp0_tx_wdata;
    logic               acp0_tx_wdreq = 1'b0;
    logic [2:0]         cap_state_dbg;
    logic [1:0]         burst_state_dbg;

    logic [BEAT_W-1:0] exp_q[$];
    logic [34:0]       exp_burst_q[$];
    logic [31:0]       exp_crc_q[$];

    int checks = 0, errors = 0;
    int trig_cnt = 0, cmpt_cnt = 0, done_cnt = 0, burst_cnt = 0, stall_cnt = 0;
    int rdy_dly = 0;
    logic wdreq_d = 1'b0;

    tc_pl_cap_data_mc #(
        .PHASE_W(PHASE_W), .POINT_W(POINT_W), .ADDR_W(ADDR_W), .DIN_W(DIN_W),
        .BEAT_W(BEAT_W), .FIFO_AW(FIFO_AW), .BURST_LEN(BURST_LEN)
    ) dut (
        .clk(clk), .rst(rst), .data_en(data_en), .data_cmpt(data_cmpt), .busy(busy),
        .cap_phase_number(cap_phase_number), .cap_points(cap_points), .cap_addr(cap_addr),
        .cap_stride(cap_stride), .cap_crc32(cap_crc32), .Gc_cap_trig(Gc_cap_trig),
        .Gc_capr_rdy(Gc_capr_rdy), .Gc_cap_cmpt(Gc_cap_cmpt), .Gc_cap_phase(Gc_cap_phase),
        .Gc_merge_data(Gc_merge_data), .Gc_mereg_datv(Gc_mereg_datv),
        .Gc_mereg_datr(Gc_mereg_datr), .acp0_tx_en(acp0_tx_en), .acp0_tx_rdy(acp0_tx_rdy),
        .acp0_tx_awaddr(acp0_tx_awaddr), .acp0_tx_awid(acp0_tx_awid),
        .acp0_tx_wdata(acp0_tx_wdata), .acp0_tx_wdreq(acp0_tx_wdreq),
        .cap_state_dbg(cap_state_dbg), .burst_state_dbg(burst_state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [DIN_W-1:0] sample_val(input int tag, input int p, input int i);
        return (DIN_W'(tag) << 48) | (DIN_W'(p) << 16) | DIN_W'(i);
    endfunction

    // bytewise MSB-first CRC32, poly 0x04C11DB7
    function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [63:0] beat);
        logic [31:0] c;
        logic [7:0]  b;
        c = c_in;
        for (int k = 7; k >= 0; k--) begin
            b = beat[k*8 +: 8];
            c = c ^ {b, 24'h0};
            for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
        end
        return c;
    endfunction

    // scoreboard: expectations queued when a job is issued
    task automatic prepare(input int nph, input int pts, input logic [31:0] addr,
                           input logic [31:0] stride, input int tag);
        logic [31:0] c, a;
        logic [63:0] beat;
        int nb;
        c  = 32'hFFFF_FFFF;
        nb = (pts + BURST_LEN - 1) / BURST_LEN;
        for (int p = 0; p < nph; p++) begin
            for (int b = 0; b < nb; b++) begin
                a = addr + 32'(p) * stride + 32'(b * BURST_BYTES);
                exp_burst_q.push_back({3'(p), a});
            end
            for (int i = 0; i < nb * BURST_LEN; i++) begin
                beat = (i < pts) ? 64'(sample_val(tag, p, i)) : 64'h0;
                exp_q.push_back(beat);
                if (i < pts) c = crc_model(c, beat);
            end
        end
        exp_crc_q.push_back(~c);
    endtask

    // driver tasks
    task automatic start_job(input int nph, input int pts, input logic [31:0] addr,
                             input logic [31:0] stride);
        @(negedge clk);
        cap_phase_number = PHASE_W'(nph - 1);
        cap_points       = POINT_W'(pts);
        cap_addr         = addr;
        cap_stride       = stride;
        data_en          = 1'b1;
        @(posedge clk);
        #1 data_en = 1'b0;
    endtask

    task automatic wait_trig(input int p);
        int n;
        logic found;
        n = 0;
        found = 1'b0;
        while (!found && n < BOUND) begin
            @(negedge clk);
            #2;
            if (Gc_cap_trig) found = 1'b1;
            n++;
        end
        check("trig_seen", 64'(found), 64'd1);
        if (found) begin
            check("trig_phase", 64'(Gc_cap_phase), 64'(p));
            check("busy_at_trig", 64'(busy), 64'd1);
        end
    endtask

    task automatic feed(input int tag, input int p, input int n);
        int k, w;
        k = 0;
        w = 0;
        while (k < n && w < BOUND) begin
            @(negedge clk);
            Gc_mereg_datv = 1'b1;
            Gc_merge_data = sample_val(tag, p, k);
            #2;
            if (Gc_mereg_datr) begin
                k++;
                w = 0;
            end else w++;
        end
        @(negedge clk);
        Gc_mereg_datv = 1'b0;
        check("feed_count", 64'(k), 64'(n));
    endtask

    task automatic run_job(input int nph, input int pts, input logic [31:0] addr,
                           input logic [31:0] stride, input int tag, input int dly,
                           input logic poke);
        int t0, c0, d0, b0, n;
        rdy_dly = dly;
        t0 = trig_cnt;
        c0 = cmpt_cnt;
        d0 = done_cnt;
        b0 = burst_cnt;
        prepare(nph, pts, addr, stride, tag);
        start_job(nph, pts, addr, stride);
        for (int p = 0; p < nph; p++) begin
            wait_trig(p);
            if (pts > 0) feed(tag, p, pts);
            if (poke && p == 0) begin
                @(negedge clk);
                cap_addr         = 32'hDEAD_0000;
                cap_points       = POINT_W'(3);
                cap_phase_number = '0;
                data_en          = 1'b1;
                @(negedge clk);
                data_en = 1'b0;
            end
        end
        n = 0;
        while (done_cnt == d0 && n < 4 * BOUND) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        check("trig_pulses", 64'(trig_cnt - t0), 64'(nph));
        check("cmpt_pulses", 64'(cmpt_cnt - c0), 64'(nph));
        check("burst_count", 64'(burst_cnt - b0), 64'(nph * ((pts + BURST_LEN - 1) / BURST_LEN)));
        check("beats_left", 64'(exp_q.size()), 64'd0);
        check("bursts_left", 64'(exp_burst_q.size()), 64'd0);
        check("crcs_left", 64'(exp_crc_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_data_cmpt", 64'(data_cmpt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_trig", 64'(Gc_cap_trig), 64'd0);
        check("rst_cap_cmpt", 64'(Gc_cap_cmpt), 64'd0);
        check("rst_datr", 64'(Gc_mereg_datr), 64'd0);
        check("rst_tx_en", 64'(acp0_tx_en), 64'd0);
        check("rst_phase", 64'(Gc_cap_phase), 64'd0);
        check("rst_awaddr", 64'(acp0_tx_awaddr), 64'd0);
        check("rst_awid", 64'(acp0_tx_awid), 64'd0);
        check("rst_wdata", 64'(acp0_tx_wdata), 64'd0);
        check("rst_crc32", 64'(cap_crc32), 64'd0);
    endtask

    // ACP responder: grant each request after rdy_dly cycles, then 16 beat requests with gaps
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst && acp0_tx_en) begin
                repeat (rdy_dly) @(negedge clk);
                @(negedge clk);
                acp0_tx_rdy = 1'b1;
                @(negedge clk);
                acp0_tx_rdy = 1'b0;
                for (int b = 0; b < BURST_LEN; b++) begin
                    acp0_tx_wdreq = 1'b1;
                    @(negedge clk);
                    if (b % 5 == 4) begin
                        acp0_tx_wdreq = 1'b0;
                        @(negedge clk);
                    end
                end
                acp0_tx_wdreq = 1'b0;
            end
        end
    end

    // monitor
    always begin
        @(negedge clk);
        #2;
        if (!rst) wdreq_d = 1'b0;
        else begin
            if (wdreq_d) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wdata_extra actual=%h required=none", acp0_tx_wdata);
                end else check("wdata", acp0_tx_wdata, exp_q.pop_front());
            end
            wdreq_d = acp0_tx_wdreq;
            if (acp0_tx_en && acp0_tx_rdy) begin
                burst_cnt++;
                if (exp_burst_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL burst_extra actual=%h required=none", acp0_tx_awaddr);
                end else check("burst_id_addr", {29'h0, acp0_tx_awid, acp0_tx_awaddr},
                               64'(exp_burst_q.pop_front()));
            end
            if (Gc_cap_trig) trig_cnt++;
            if (Gc_cap_cmpt) cmpt_cnt++;
            if (Gc_mereg_datv && !Gc_mereg_datr && cap_state_dbg == 3'd3) stall_cnt++;
            if (data_cmpt) begin
                done_cnt++;
                if (exp_crc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL crc_extra actual=%h required=none", cap_crc32);
                end else check("cap_crc32", 64'(cap_crc32), 64'(exp_crc_q.pop_front()));
            end
        end
    end

    initial begin
        int s0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_job(1, 16, 32'h1000_0000, 32'h0, 0, 0, 1'b0);
        run_job(4, 20, 32'h2000_0000, 32'h400, 8'h5A, 1, 1'b1);

        s0 = stall_cnt;
        run_job(1, 100, 32'h4000_0000, 32'h0, 8'hC3, 50, 1'b0);
        check("datr_dropped", 64'(stall_cnt > s0), 64'd1);

        run_job(2, 0, 32'h5000_0000, 32'h100, 1, 0, 1'b0);
        check("crc_no_samples", 64'(cap_crc32), 64'h0);

        run_job(1, 32, 32'hFFFF_FFC0, 32'h0, 8'h77, 0, 1'b0);

        // abort a job mid-capture, then run a fresh one
        rdy_dly = 0;
        start_job(1, 40, 32'h3000_0000, 32'h0);
        wait_trig(0);
        feed(8'hEE, 0, 10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        exp_burst_q.delete();
        exp_crc_q.delete();
        @(negedge clk);
        rst = 1'b1;
        run_job(2, 24, 32'h3000_0000, 32'h200, 8'h21, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
